// File: rtl/gol_gen_controller.sv
// gol_gen_controller: generation sequencer for the 8x8 Game of Life core.
// Owns the current grid register and decides when to commit the evolve
// datapath result. Commits come from a rate divider (free-run) or from a
// step pulse. The block halts on a still life or an empty board, and loads
// a new grid from the user seed or the LFSR.
module gol_gen_controller #(
   parameter int DIV_W  = 26,
   parameter int GEN_W  = 16,
   parameter int DP_LAT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      seed_in,
   input  logic [63:0]      lfsr_in,
   input  logic             load,
   input  logic             use_rand,
   input  logic             run,
   input  logic             step,
   input  logic [DIV_W-1:0] rate,
   input  logic [63:0]      next_grid,
   output logic [63:0]      grid,
   output logic [GEN_W-1:0] gen_count,
   output logic [1:0]       state,
   output logic             stable,
   output logic             extinct,
   output logic             evolve_pulse
);

   // The settle counter must be able to hold DP_LAT, and it must be at least 1 bit wide.
   localparam int SW = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_PAUSED  = 2'b01,
      S_RUNNING = 2'b10,
      S_HALTED  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      grid_q, grid_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             stable_q, stable_d;
   logic             extinct_q, extinct_d;
   logic             pulse_q, pulse_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [SW-1:0]    settle_q, settle_d;

   logic ready;
   logic tick;
   logic commit;

   // The datapath output is trusted only once DP_LAT cycles have passed since the last grid write.
   assign ready = (settle_q == '0);
   assign tick  = (state_q == S_RUNNING) && (div_q >= rate);

   // Next-state logic. A load overrides everything. Otherwise the current state decides whether a commit happens this cycle.
   always_comb begin
      state_d   = state_q;
      grid_d    = grid_q;
      gen_d     = gen_q;
      stable_d  = stable_q;
      extinct_d = extinct_q;
      pulse_d   = 1'b0;
      div_d     = div_q;
      settle_d  = ready ? settle_q : settle_q - SW'(1);
      commit    = 1'b0;

      if (load) begin
         grid_d    = use_rand ? lfsr_in : seed_in;
         gen_d     = '0;
         stable_d  = 1'b0;
         extinct_d = 1'b0;
         div_d     = '0;
         settle_d  = SW'(DP_LAT);
         state_d   = S_PAUSED;
      end else begin
         case (state_q)
            S_PAUSED: begin
               if (run) begin
                  state_d = S_RUNNING;
                  div_d   = '0;
               end else if (step && ready) begin
                  commit = 1'b1;
               end
            end
            S_RUNNING: begin
               if (!run) begin
                  state_d = S_PAUSED;
               end else if (tick) begin
                  // A tick that arrives while the datapath is still settling holds the divider, so the commit fires on the first ready cycle.
                  if (ready) begin
                     commit = 1'b1;
                     div_d  = '0;
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            default: ;
         endcase
      end

      if (commit) begin
         if (next_grid == grid_q) begin
            // A still life leaves the grid untouched and halts without a pulse.
            stable_d  = 1'b1;
            extinct_d = 1'b0;
            state_d   = S_HALTED;
         end else begin
            grid_d    = next_grid;
            settle_d  = SW'(DP_LAT);
            pulse_d   = 1'b1;
            stable_d  = 1'b0;
            extinct_d = 1'b0;
            if (gen_q != {GEN_W{1'b1}})
               gen_d = gen_q + GEN_W'(1);
            if (next_grid == '0) begin
               extinct_d = 1'b1;
               state_d   = S_HALTED;
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         grid_q    <= '0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b0;
         pulse_q   <= 1'b0;
         div_q     <= '0;
         settle_q  <= '0;
      end else begin
         state_q   <= state_d;
         grid_q    <= grid_d;
         gen_q     <= gen_d;
         stable_q  <= stable_d;
         extinct_q <= extinct_d;
         pulse_q   <= pulse_d;
         div_q     <= div_d;
         settle_q  <= settle_d;
      end
   end

   assign grid         = grid_q;
   assign gen_count    = gen_q;
   assign state        = state_q;
   assign stable       = stable_q;
   assign extinct      = extinct_q;
   assign evolve_pulse = pulse_q;

endmodule

// File: tb/tb_gol_gen_controller.sv
// Bench for gol_gen_controller: a combinational-latency instance and a
// DP_LAT=2 instance share the stimulus. A dead-boundary Life model drives next_grid.
// Expected commits are queued and matched against evolve_pulse.
module tb_gol_gen_controller;

   localparam int DIV_W = 26;
   localparam int GEN_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [63:0]      seed_in, lfsr_in;
   logic             load, use_rand, run, step;
   logic [DIV_W-1:0] rate;

   logic [63:0]      grid0, grid2, next0, next2;
   logic [GEN_W-1:0] gen0, gen2;
   logic [1:0]       state0, state2;
   logic             stable0, stable2, extinct0, extinct2, pulse0, pulse2;

   typedef struct {
      logic [63:0]      g;
      logic [GEN_W-1:0] n;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc_n = 0;
   int   np0 = 0, np2 = 0;
   int   last0 = 0, last2 = 0;
   bit   have0 = 0, have2 = 0;
   bit   sb_en = 1, per_en0 = 0, per_en2 = 0;
   int   exp_per0 = 4, exp_per2 = 3;
   int   base;

   always #5 clk = ~clk;

   function automatic logic [63:0] life(input logic [63:0] g);
      logic [63:0] r;
      int n, rr, cc;
      r = '0;
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++) begin
                  rr = y + dy;
                  cc = x + dx;
                  if ((dy != 0 || dx != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                     n += int'(g[rr*8+cc]);
               end
            r[y*8+x] = g[y*8+x] ? (n == 2 || n == 3) : (n == 3);
         end
      return r;
   endfunction

   assign next0 = life(grid0);
   assign next2 = life(grid2);

   gol_gen_controller #(.DIV_W(DIV_W), .GEN_W(GEN_W), .DP_LAT(0)) u_dut0 (
      .clk(clk), .reset(reset), .seed_in(seed_in), .lfsr_in(lfsr_in),
      .load(load), .use_rand(use_rand), .run(run), .step(step), .rate(rate),
      .next_grid(next0), .grid(grid0), .gen_count(gen0), .state(state0),
      .stable(stable0), .extinct(extinct0), .evolve_pulse(pulse0));

   gol_gen_controller #(.DIV_W(DIV_W), .GEN_W(GEN_W), .DP_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .seed_in(seed_in), .lfsr_in(lfsr_in),
      .load(load), .use_rand(use_rand), .run(run), .step(step), .rate(rate),
      .next_grid(next2), .grid(grid2), .gen_count(gen2), .state(state2),
      .stable(stable2), .extinct(extinct2), .evolve_pulse(pulse2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [63:0] g, input int n);
      exp_t x;
      x.g = g;
      x.n = GEN_W'(n);
      sbq.push_back(x);
   endtask

   task automatic do_load(input logic [63:0] s);
      seed_in = s;
      load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Pulse monitor: scoreboard match for dut0, commit period for both instances.
   always @(negedge clk) begin
      if (pulse0) begin
         np0++;
         if (sb_en) begin
            if (sbq.size() == 0) chk("sb_unexpected_pulse", 64'(sbq.size()), 64'd1);
            else begin
               e = sbq.pop_front();
               chk("sb_grid", grid0, e.g);
               chk("sb_gen", 64'(gen0), 64'(e.n));
            end
         end
         if (per_en0 && have0) chk("period0", 64'(cyc_n - last0), 64'(exp_per0));
         have0 = per_en0;
         last0 = cyc_n;
      end
      if (pulse2) begin
         np2++;
         if (per_en2 && have2) chk("period2", 64'(cyc_n - last2), 64'(exp_per2));
         have2 = per_en2;
         last2 = cyc_n;
      end
   end

   initial begin
      reset = 1'b1; seed_in = '0; lfsr_in = '0; load = 0; use_rand = 0;
      run = 0; step = 0; rate = '0;
      cyc(2);
      reset = 1'b0;
      chk("rst_grid", grid0, 64'd0);
      chk("rst_gen", 64'(gen0), 64'd0);
      chk("rst_state", 64'(state0), 64'd0);
      chk("rst_stable", 64'(stable0), 64'd0);
      chk("rst_extinct", 64'(extinct0), 64'd0);
      chk("rst_pulse", 64'(pulse0), 64'd0);

      // IDLE ignores run and step
      run = 1; step = 1; cyc(); step = 0; cyc(2);
      chk("idle_grid", grid0, 64'd0);
      chk("idle_state", 64'(state0), 64'd0);
      run = 0;

      // Blinker single steps
      do_load(64'h0E00);
      chk("ld_grid", grid0, 64'h0E00);
      chk("ld_state", 64'(state0), 64'd1);
      chk("ld_pulse", 64'(pulse0), 64'd0);
      cyc(3);
      push(64'h40404, 1);
      step = 1; cyc(); step = 0;
      chk("st1_grid", grid0, 64'h40404);
      chk("st1_gen", 64'(gen0), 64'd1);
      chk("st1_pulse", 64'(pulse0), 64'd1);
      cyc();
      chk("st1_pulse_end", 64'(pulse0), 64'd0);
      cyc(2);
      push(64'h0E00, 2);
      step = 1; cyc(); step = 0;
      chk("st2_grid", grid0, 64'h0E00);
      chk("st2_gen", 64'(gen0), 64'd2);
      cyc(3);

      // Free-run with rate=3: one commit every 4 cycles
      do_load(64'h0E00);
      cyc(3);
      for (int k = 1; k <= 10; k++) push((k % 2) ? 64'h40404 : 64'h0E00, k);
      rate = 3; per_en0 = 1; base = np0;
      run = 1;
      for (int k = 0; k < 200 && (np0 - base) < 10; k++) cyc();
      run = 0;
      chk("fr_pulses", 64'(np0 - base), 64'd10);
      cyc(8);
      per_en0 = 0;
      chk("fr_gen", 64'(gen0), 64'd10);
      chk("fr_state", 64'(state0), 64'd1);
      chk("fr_no_more", 64'(np0 - base), 64'd10);

      // Still life halts without a pulse
      do_load(64'h0000_0018_1800_0000);
      cyc(3);
      rate = 0; run = 1;
      cyc(2);
      chk("sl_state", 64'(state0), 64'd3);
      chk("sl_stable", 64'(stable0), 64'd1);
      chk("sl_gen", 64'(gen0), 64'd0);
      chk("sl_grid", grid0, 64'h0000_0018_1800_0000);
      step = 1; cyc(); step = 0; cyc();
      chk("sl_frozen", 64'(state0), 64'd3);
      run = 0;
      lfsr_in = 64'h0E00; use_rand = 1;
      do_load(64'hDEAD);
      use_rand = 0;
      chk("rnd_grid", grid0, 64'h0E00);
      chk("rnd_state", 64'(state0), 64'd1);
      chk("rnd_stable", 64'(stable0), 64'd0);
      chk("rnd_gen", 64'(gen0), 64'd0);
      cyc(3);

      // Extinction
      do_load(64'h0200);
      cyc(3);
      push(64'd0, 1);
      step = 1; cyc(); step = 0;
      chk("ex_grid", grid0, 64'd0);
      chk("ex_extinct", 64'(extinct0), 64'd1);
      chk("ex_gen", 64'(gen0), 64'd1);
      chk("ex_state", 64'(state0), 64'd3);
      step = 1; cyc(); step = 0;
      chk("ex_halted", 64'(gen0), 64'd1);

      // Zero seed stepped is a still life
      do_load(64'd0);
      cyc(3);
      step = 1; cyc(); step = 0;
      chk("z_stable", 64'(stable0), 64'd1);
      chk("z_state", 64'(state0), 64'd3);
      chk("z_extinct", 64'(extinct0), 64'd0);

      // Latency: a step that arrives while settling is dropped, and commits come every 3 cycles
      sb_en = 0;
      do_load(64'h0E00);
      step = 1; cyc(); step = 0;
      chk("lat_drop_gen", 64'(gen2), 64'd0);
      cyc(3);
      chk("lat_noqueue", 64'(gen2), 64'd0);
      chk("lat_grid", grid2, 64'h0E00);
      rate = 0; per_en2 = 1; base = np2;
      run = 1;
      for (int k = 0; k < 200 && (np2 - base) < 6; k++) cyc();
      run = 0;
      cyc(3);
      per_en2 = 0;
      chk("lat_gen", 64'(gen2), 64'd6);
      chk("lat_state", 64'(state2), 64'd1);

      // A load coinciding with a due tick wins
      do_load(64'h0E00);
      cyc(3);
      run = 1; cyc(3);
      do_load(64'h0200);
      chk("pr_grid", grid0, 64'h0200);
      chk("pr_gen", 64'(gen0), 64'd0);
      chk("pr_state", 64'(state0), 64'd1);
      chk("pr_pulse", 64'(pulse0), 64'd0);
      cyc();
      chk("pr_run", 64'(state0), 64'd2);
      run = 0;
      cyc(2);
      sb_en = 1;

      // A load and a step in the same cycle: the load wins
      seed_in = 64'h0E00; load = 1; step = 1; cyc(); load = 0; step = 0;
      chk("ls_grid", grid0, 64'h0E00);
      chk("ls_gen", 64'(gen0), 64'd0);
      cyc();
      chk("ls_dropped", 64'(gen0), 64'd0);

      // Reset asserted mid-run
      sb_en = 0;
      rate = 1; run = 1; cyc(6);
      reset = 1; cyc(); reset = 0; run = 0;
      chk("mr_grid", grid0, 64'd0);
      chk("mr_gen", 64'(gen0), 64'd0);
      chk("mr_state", 64'(state0), 64'd0);
      chk("mr_pulse", 64'(pulse0), 64'd0);
      cyc(2);

      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
